// File: rtl/pmc_uart_tx.sv
// pmc_uart_tx: snapshots the PMC stall / arithmetic / memory-access counters
// and the Q8.8 CPI value on a dump request, then sends them as a fixed
// 16-byte frame (header, 14 payload bytes, XOR checksum) over an 8N1 UART
// transmit line. tx is always driven from a flop.
module pmc_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dump_req,
    input  logic [31:0] stall_count_in,
    input  logic [31:0] arith_count_in,
    input  logic [31:0] mem_access_count_in,
    input  logic [15:0] cpi_q78_in,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]      HEADER    = 8'hA5;
    localparam logic [3:0]      LAST_BYTE = 4'd15;

    logic [1:0]    state_reg;
    logic [CW-1:0] baud_cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [3:0]    byte_idx_reg;
    logic [7:0]    shift_reg;
    logic [7:0]    checksum_reg;
    logic [31:0]   snap_stall_reg;
    logic [31:0]   snap_arith_reg;
    logic [31:0]   snap_mem_reg;
    logic [15:0]   snap_cpi_reg;
    logic          tx_reg;
    logic          busy_reg;
    logic          done_reg;

    // Frame byte table built from the snapshot; byte 15 is the running
    // checksum, which is complete by the time byte 15 is loaded.
    logic [7:0] frame_bytes [16];
    logic [7:0] byte_cur;
    logic       is_payload;
    logic       baud_done;

    assign frame_bytes[0]  = HEADER;
    assign frame_bytes[15] = checksum_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_counters
            assign frame_bytes[1 + gi] = snap_stall_reg[8*gi +: 8];
            assign frame_bytes[5 + gi] = snap_arith_reg[8*gi +: 8];
            assign frame_bytes[9 + gi] = snap_mem_reg[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_cpi
            assign frame_bytes[13 + gi] = snap_cpi_reg[8*gi +: 8];
        end
    endgenerate

    assign byte_cur   = frame_bytes[byte_idx_reg];
    assign is_payload = (byte_idx_reg != 4'd0) && (byte_idx_reg != LAST_BYTE);
    assign baud_done  = (baud_cnt_reg == BAUD_LAST);

    // Byte/bit sequencer: every bit holds for CLKS_PER_BIT cycles, bytes run back to back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            baud_cnt_reg   <= '0;
            bit_idx_reg    <= '0;
            byte_idx_reg   <= '0;
            shift_reg      <= '0;
            checksum_reg   <= '0;
            snap_stall_reg <= '0;
            snap_arith_reg <= '0;
            snap_mem_reg   <= '0;
            snap_cpi_reg   <= '0;
            tx_reg         <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (dump_req) begin
                        snap_stall_reg <= stall_count_in;
                        snap_arith_reg <= arith_count_in;
                        snap_mem_reg   <= mem_access_count_in;
                        snap_cpi_reg   <= cpi_q78_in;
                        state_reg      <= ST_START;
                        baud_cnt_reg   <= '0;
                        bit_idx_reg    <= '0;
                        byte_idx_reg   <= '0;
                        checksum_reg   <= '0;
                        tx_reg         <= 1'b0;
                        busy_reg       <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        // Load the byte: bit 0 goes straight to tx, the rest wait in the shifter.
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        state_reg    <= ST_DATA;
                        tx_reg       <= byte_cur[0];
                        shift_reg    <= {1'b0, byte_cur[7:1]};
                        if (is_payload) begin
                            checksum_reg <= checksum_reg ^ byte_cur;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= ST_STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CW'(1);
                    end
                end
                default: begin // ST_STOP
                    if (baud_done) begin
                        baud_cnt_reg <= '0;
                        if (byte_idx_reg == LAST_BYTE) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 4'd1;
                            state_reg    <= ST_START;
                            tx_reg       <= 1'b0;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CW'(1);
                    end
                end
            endcase
        end
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: doc/pmc_uart_tx.md
# pmc_uart_tx

Read-out side of the performance-monitor counters. On a dump request it snapshots the stall, arithmetic, memory-access and CPI (Q8.8) values produced by the PMC unit and sends them off-chip as a fixed 16-byte frame over an 8N1 UART transmit line. It sits beside the PMC unit in the processor metrics block; the integrator connects bits [31:0] of each 256-bit PMC count bus and bits [15:0] of the CPI bus.

## Interface
- CLKS_PER_BIT, default 434 (50 MHz / 115200 baud): clock cycles per UART bit; legal range is 2 or more.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  reset, asynchronous, active-high.
- dump_req  in  1  single-cycle request to snapshot the counters and send one frame.
- stall_count_in  in  32  stall counter value.
- arith_count_in  in  32  arithmetic-operation counter value.
- mem_access_count_in  in  32  memory-access counter value.
- cpi_q78_in  in  16  cycles per instruction, unsigned fixed-point with 8 fraction bits.
- tx  out  1  UART serial output; idle high.
- busy  out  1  a frame is being sent; dump_req is ignored while this is high.
- done  out  1  one-cycle pulse when the last stop bit of a frame completes.

## Operation
- Reset values: tx=1, busy=0, done=0. Reset also clears the FSM to IDLE, the byte index to 0, the bit index to 0, the baud counter to 0 and the checksum to 0.
- Accept: dump_req is accepted when it is high on a rising edge while the FSM is in IDLE.
  - On that edge, all four inputs are latched into a snapshot register.
  - busy is set, the byte index is cleared and the checksum is cleared.
  - The frame always carries the snapshot values; input changes after the accept edge have no effect on it.
- Frame content, bytes 0..15 in order:
  - 0: header 0xA5.
  - 1-4: stall count, least significant byte first.
  - 5-8: arithmetic count, least significant byte first.
  - 9-12: memory-access count, least significant byte first.
  - 13-14: CPI, low byte first.
  - 15: XOR of bytes 1-14. The header is not included in the checksum.
- Byte format: one start bit (0), eight data bits sent LSB first, one stop bit (1). Each bit holds for exactly CLKS_PER_BIT cycles.
- Byte FSM states:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after the 8th data bit.
  - STOP -> START (byte index +1) after CLKS_PER_BIT cycles if the index is below 15.
  - STOP -> IDLE when the index is 15. done pulses on this transition.
- Checksum accumulates each payload byte as it is loaded into the shift register.
- dump_req while busy=1 is dropped. Requests are not queued.
- Reset mid-frame: the frame aborts immediately, tx goes to 1 asynchronously, and no done pulse is produced.

## Timing
- Accept edge at cycle T: busy=1 and tx=0 (start bit of byte 0) from cycle T+1.
- Bit k of byte n (k=0 is the start bit, k=9 is the stop bit) occupies cycles T+1+(10n+k)·CLKS_PER_BIT through T+(10n+k+1)·CLKS_PER_BIT.
  - A frame takes 160·CLKS_PER_BIT cycles.
  - Bytes are back-to-back with no idle gap between them.
- done=1 and busy=0 in cycle T+1+160·CLKS_PER_BIT. tx remains 1.
- A dump_req sampled in the done cycle is accepted, because the FSM is in IDLE that cycle. Its start bit appears the following cycle.
- tx is driven straight from a flop, so it carries no combinational glitches.

## Test plan
- Reset, then idle for 100 cycles -> tx=1, busy=0, done=0 throughout.
- CLKS_PER_BIT=4 with stall=0x00000010, arith=0x12345678, mem=0x0000ABCD, cpi=0x0500, one-cycle dump_req.
  - The UART monitor must decode: A5 10 00 00 00 78 56 34 12 CD AB 00 00 00 05 7B.
  - done must pulse exactly 641 cycles after the accept edge.
- Same frame as above, but change every input to 0xFFFFFFFF one cycle after accept -> bytes are unchanged and the checksum is still 0x7B.
- Pulse dump_req 50 and 300 cycles after accept -> exactly one frame is sent.
  - Then assert dump_req in the done cycle -> a second frame's start bit appears in the next cycle.
- Assert reset during byte 7 -> tx=1 within the same cycle, busy=0 and no done pulse.
  - A dump_req after reset is released -> a complete, correct frame.
- All inputs zero -> frame is A5 followed by fourteen 00 bytes and a checksum of 00.
